// File: rtl/spi_pkg.sv
// Shared SPI slave constants: word/data widths, command codes and the FSM state encoding.
// Imported by the slave and by the memory-stage side of the wrapper.
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // The selector bit picks write vs read; a read goes to the data phase only
    // once a read address has been latched by a previous frame.
    function automatic state_t cmd_state(input logic sel, input logic rd_addr_seen);
        if (!sel) begin
            return WRITE;
        end
        return rd_addr_seen ? READ_DATA : READ_ADD;
    endfunction

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command words for the memory stage and
// serialises the 8-bit read byte back on MISO, all in the SCK (clk) domain.
module spi_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

    state_t              r_state;
    // The tenth word bit is taken straight from MOSI, so only nine bits need storing.
    logic [WORD_W-2:0]   r_shift;
    logic [3:0]          r_bit_cnt;
    logic                r_frame_done;
    logic                r_rd_addr_flag;
    logic [DATA_W-2:0]   r_tx_shift;
    logic [2:0]          r_tx_cnt;
    logic                r_tx_busy;
    logic                r_tx_done;

    logic [WORD_W-1:0]   w_word;
    logic                w_tx_window;

    assign w_word      = {r_shift, MOSI};
    assign w_tx_window = (r_state == READ_DATA) && r_frame_done && !r_tx_busy && !r_tx_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= '0;
            r_frame_done   <= 1'b0;
            r_rd_addr_flag <= 1'b0;
            r_tx_shift     <= '0;
            r_tx_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            MISO           <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // Deselect wins in every active state; the read-address flag survives it.
            if ((r_state != IDLE) && SS_n) begin
                r_state      <= IDLE;
                r_shift      <= '0;
                r_bit_cnt    <= '0;
                r_frame_done <= 1'b0;
                r_tx_shift   <= '0;
                r_tx_cnt     <= '0;
                r_tx_busy    <= 1'b0;
                r_tx_done    <= 1'b0;
                MISO         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!SS_n) begin
                            r_state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        r_state <= cmd_state(MOSI, r_rd_addr_flag);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!r_frame_done) begin
                            r_shift <= w_word[WORD_W-2:0];
                            if (r_bit_cnt == LAST_BIT) begin
                                rx_data      <= w_word;
                                rx_valid     <= 1'b1;
                                r_frame_done <= 1'b1;
                                if (r_state == READ_ADD) begin
                                    r_rd_addr_flag <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else if (r_tx_busy) begin
                            if (r_tx_cnt != 3'd0) begin
                                MISO       <= r_tx_shift[DATA_W-2];
                                r_tx_shift <= {r_tx_shift[DATA_W-3:0], 1'b0};
                                r_tx_cnt   <= r_tx_cnt - 3'd1;
                            end else begin
                                MISO           <= 1'b0;
                                r_tx_busy      <= 1'b0;
                                r_tx_done      <= 1'b1;
                                r_rd_addr_flag <= 1'b0;
                            end
                        end else if (w_tx_window && tx_valid) begin
                            MISO       <= tx_data[DATA_W-1];
                            r_tx_shift <= tx_data[DATA_W-2:0];
                            r_tx_cnt   <= 3'(DATA_W - 1);
                            r_tx_busy  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: a frame-level reference model predicts MISO, rx_valid
// and rx_data per clock, and a separate monitor compares them against the DUT.
module tb_spi_slave;
    import spi_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic              miso;
        logic              rxv;
        logic [WORD_W-1:0] rxd;
    } exp_t;

    exp_t              exp_q[$];
    logic [WORD_W-1:0] rx_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cycle  = 0;

    // Reference model: where the master is within a frame, and what the slave owes it.
    bit                m_idle     = 1'b1;
    bit                m_need_sel = 1'b0;
    int                m_nbits    = 0;
    logic [WORD_W-1:0] m_word     = '0;
    int                m_mode     = 0;     // 0 write, 1 read address, 2 read data
    bit                m_flag     = 1'b0;
    bit                m_window   = 1'b0;
    bit                m_sending  = 1'b0;
    int                m_rem      = 0;
    logic [DATA_W-1:0] m_byte     = '0;
    logic [WORD_W-1:0] m_rx_hold  = '0;

    task automatic model_step(input logic rn, input logic ss, input logic mosi,
                              input logic txv, input logic [7:0] txd);
        exp_t e;
        e.miso = 1'b0;
        e.rxv  = 1'b0;
        if (!rn) begin
            m_idle = 1; m_need_sel = 0; m_nbits = 0; m_flag = 0;
            m_window = 0; m_sending = 0; m_rem = 0; m_rx_hold = '0;
        end else if (ss) begin
            m_idle = 1; m_need_sel = 0; m_nbits = 0;
            m_window = 0; m_sending = 0; m_rem = 0;
        end else if (m_idle) begin
            m_idle = 0; m_need_sel = 1;
        end else if (m_need_sel) begin
            m_need_sel = 0; m_nbits = 0; m_word = '0;
            m_mode = (mosi == 1'b0) ? 0 : (m_flag ? 2 : 1);
        end else if (m_nbits < WORD_W) begin
            m_word  = {m_word[WORD_W-2:0], mosi};
            m_nbits = m_nbits + 1;
            if (m_nbits == WORD_W) begin
                e.rxv = 1'b1;
                m_rx_hold = m_word;
                rx_q.push_back(m_word);
                if (m_mode == 1) m_flag = 1;
                if (m_mode == 2) m_window = 1;
            end
        end else if (m_window && txv) begin
            m_window = 0; m_sending = 1; m_byte = txd; m_rem = 7;
            e.miso = txd[7];
        end else if (m_sending) begin
            if (m_rem > 0) begin
                e.miso = m_byte[m_rem-1];
                m_rem  = m_rem - 1;
            end else begin
                m_sending = 0;
                m_flag    = 0;
            end
        end
        e.rxd = m_rx_hold;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rn, input logic ss, input logic mosi,
                       input logic txv, input logic [7:0] txd);
        rst_n    = rn;
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = txv;
        tx_data  = txd;
        model_step(rn, ss, mosi, txv, txd);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    // One master transaction: select, selector bit, word bits (optionally aborted),
    // then an optional tx_valid return and room for the read byte, then deselect.
    task automatic frame(input logic sel, input logic [9:0] word, input int abort_at,
                         input int tx_delay, input logic [7:0] txd, input int rst_at);
        cyc(1, 0, rbit(), 0, rbyte());
        cyc(1, 0, sel, 0, rbyte());
        for (int i = 0; i < WORD_W; i++) begin
            if (i == abort_at) begin
                cyc(1, 1, rbit(), 0, rbyte());
                cyc(1, 1, rbit(), 0, rbyte());
                return;
            end
            cyc(1, 0, word[9-i], ($urandom_range(0, 7) == 0), rbyte());
        end
        if (tx_delay >= 0) begin
            repeat (tx_delay) cyc(1, 0, rbit(), 0, rbyte());
            cyc(1, 0, rbit(), 1, txd);
            for (int k = 0; k < 10; k++) begin
                if (k == rst_at) begin
                    cyc(0, 0, rbit(), 0, rbyte());
                    cyc(1, 1, rbit(), 0, rbyte());
                    return;
                end
                cyc(1, 0, rbit(), (k == 9), rbyte());
            end
        end
        cyc(1, 1, rbit(), 0, rbyte());
        if ($urandom_range(0, 1) == 1) cyc(1, 1, rbit(), 0, rbyte());
    endtask

    exp_t              mon_e;
    logic [WORD_W-1:0] mon_w;

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (MISO !== mon_e.miso) begin
                errors++;
                $display("FAIL miso cycle=%0d got=%b exp=%b", cycle, MISO, mon_e.miso);
            end
            checks++;
            if (rx_valid !== mon_e.rxv) begin
                errors++;
                $display("FAIL rx_valid cycle=%0d got=%b exp=%b", cycle, rx_valid, mon_e.rxv);
            end
            checks++;
            if (rx_data !== mon_e.rxd) begin
                errors++;
                $display("FAIL rx_data_hold cycle=%0d got=%h exp=%h", cycle, rx_data, mon_e.rxd);
            end
        end
        if (rx_valid === 1'b1) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_word cycle=%0d got=%h exp=none", cycle, rx_data);
            end else begin
                mon_w = rx_q.pop_front();
                if (rx_data !== mon_w) begin
                    errors++;
                    $display("FAIL rx_word cycle=%0d got=%h exp=%h", cycle, rx_data, mon_w);
                end else begin
                    $display("rx word cycle=%0d data=%h", cycle, rx_data);
                end
            end
        end
    end

    initial begin
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 1, 1, 8'hFF);
        cyc(1, 1, 0, 0, 8'h00);
        // Write address, write data, read address, read data returning 0xAA.
        frame(1'b0, {CMD_WR_ADDR, 8'h05}, WORD_W, -1, 8'h00, -1);
        frame(1'b0, {CMD_WR_DATA, 8'hAA}, WORD_W, 2, 8'h3C, -1);
        frame(1'b1, {CMD_RD_ADDR, 8'h05}, WORD_W, 1, 8'hFF, -1);
        frame(1'b1, {CMD_RD_DATA, rbyte()}, WORD_W, 2, 8'hAA, -1);
        // Flag now clear: a read selector goes back to the address phase and ignores tx_valid.
        frame(1'b1, {CMD_RD_ADDR, 8'h11}, WORD_W, 0, 8'hFF, -1);
        // Abort after five word bits, then a clean frame.
        frame(1'b0, {CMD_WR_DATA, 8'h5A}, 5, -1, 8'h00, -1);
        frame(1'b0, {CMD_WR_DATA, 8'hC3}, WORD_W, -1, 8'h00, -1);
        // Aborted read-data frame keeps the flag; the next read goes straight to data.
        frame(1'b1, {CMD_RD_DATA, 8'h00}, 4, -1, 8'h00, -1);
        frame(1'b1, {CMD_RD_DATA, 8'h00}, WORD_W, 0, 8'h96, -1);
        // Reset while MISO is shifting, then a read must restart at the address phase.
        frame(1'b1, {CMD_RD_ADDR, 8'h22}, WORD_W, -1, 8'h00, -1);
        frame(1'b1, {CMD_RD_DATA, 8'h00}, WORD_W, 1, 8'hF0, 3);
        frame(1'b1, {CMD_RD_ADDR, 8'h33}, WORD_W, 1, 8'hFF, -1);
        for (int n = 0; n < 150; n++) begin
            logic       sel;
            logic [9:0] w;
            sel = rbit();
            w   = 10'($urandom);
            if ($urandom_range(0, 3) != 0) w[9] = sel;
            frame(sel, w,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : WORD_W,
                  int'($urandom_range(0, 3)), rbyte(),
                  ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 7)) : -1);
        end
        repeat (3) cyc(1, 1, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain rx_pending=%0d exp_pending=%0d required=0", rx_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
